basic_system_pio_poller: RTL

Avalon-MM master that sits on the system interconnect opposite the PIO slaves. It periodically reads an input PIO data register (e.g. the switches port) and debounces the sampled value. It writes each newly stable value to an output PIO data register (e.g. the LEDs port), which links switches to LEDs in hardware with no Nios II involvement.

---
 rtl/basic_system_pio_poller_pkg.sv | 18 +
 rtl/basic_system_pio_poller_debounce.sv | 73 +++++++
 rtl/basic_system_pio_poller.sv | 184 ++++++++++++++++++
 3 files changed

// File: rtl/basic_system_pio_poller_pkg.sv
// basic_system_pio_poller_pkg
//
// Shared types and constants for the PIO poller slice.
//   state_t        : poller FSM encoding (IDLE, RD_REQ, RD_WAIT, EVAL, WR_REQ)
//   BYTEENABLE_ALL : every bus access is a full 32-bit word access
package basic_system_pio_poller_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        RD_REQ  = 3'd1,
        RD_WAIT = 3'd2,
        EVAL    = 3'd3,
        WR_REQ  = 3'd4
    } state_t;

    localparam logic [3:0] BYTEENABLE_ALL = 4'hF;

endpackage

// File: rtl/basic_system_pio_poller_debounce.sv
// basic_system_pio_poller_debounce
//
// Debounces successive samples of the input PIO and decides when a newly
// stable value must be forwarded.
//
// Ports:
//   clk          in   system clock
//   reset        in   asynchronous active-high reset
//   sample_valid in   one-cycle strobe: 'sample' holds a fresh poll result
//   sample       in   DATA_W sampled value
//   value        out  DATA_W last committed value
//   commit       out  combinational strobe, high with sample_valid when this
//                     sample makes a commit due; value follows on the next edge
module basic_system_pio_poller_debounce
    import basic_system_pio_poller_pkg::*;
#(
    parameter int DATA_W           = 4,
    parameter int DEBOUNCE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              sample_valid,
    input  logic [DATA_W-1:0] sample,
    output logic [DATA_W-1:0] value,
    output logic              commit
);

    localparam int              CW        = $clog2(DEBOUNCE_SAMPLES + 1);
    localparam logic [CW-1:0]   COUNT_MAX = CW'(DEBOUNCE_SAMPLES);
    localparam logic [CW-1:0]   COUNT_ONE = CW'(1);

    logic [DATA_W-1:0] candidate;
    logic [DATA_W-1:0] candidate_next;
    logic [CW-1:0]     count;
    logic [CW-1:0]     count_next;
    logic              first_done;

    // Next candidate/count as if the current sample were taken. The stable
    // counter saturates so a long-held input never wraps back below the
    // threshold.
    always_comb begin
        candidate_next = candidate;
        count_next     = count;
        if (sample != candidate) begin
            candidate_next = sample;
            count_next     = COUNT_ONE;
        end else if (count != COUNT_MAX) begin
            count_next = count + COUNT_ONE;
        end
    end

    // The very first stable value after reset is forwarded even when it
    // equals the reset value of 'value' (0), hence the first_done term.
    assign commit = sample_valid && (count_next == COUNT_MAX) &&
                    ((candidate_next != value) || !first_done);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            candidate  <= '0;
            count      <= '0;
            value      <= '0;
            first_done <= 1'b0;
        end else if (sample_valid) begin
            candidate <= candidate_next;
            count     <= count_next;
            if (commit) begin
                value      <= candidate_next;
                first_done <= 1'b1;
            end
        end
    end

endmodule

// File: rtl/basic_system_pio_poller.sv
// basic_system_pio_poller
//
// Avalon-MM master that periodically reads an input PIO data register,
// debounces the sampled value and writes every newly stable value to an
// output PIO data register.
//
// Ports:
//   clk, reset           system clock, asynchronous active-high reset
//   enable               polling enable; low holds the timer at its reload
//                        value and prevents new polls (a running poll finishes)
//   avm_address          byte address (SRC_ADDR except during WR_REQ)
//   avm_read, avm_write  command strobes
//   avm_byteenable       always 4'hF
//   avm_writedata        committed value, zero-extended to 32 bits
//   avm_readdata         read data, only [DATA_W-1:0] is used
//   avm_readdatavalid    read data qualifier, honoured only in RD_WAIT
//   avm_waitrequest      slave stall
//   value                last committed value
//   changed              one-cycle pulse the cycle after a write is accepted
//   busy                 high whenever the FSM is not in IDLE
//
// Handshake: a command (read or write) is presented with address/data and is
// held unchanged every cycle that avm_waitrequest is high; it is accepted on
// the first clock edge where avm_waitrequest is low, and the FSM drops the
// command in the same edge. Read data is taken on the edge where
// avm_readdatavalid is high while in RD_WAIT.
module basic_system_pio_poller
    import basic_system_pio_poller_pkg::*;
#(
    parameter logic [31:0] SRC_ADDR         = 32'h0000_0000,
    parameter logic [31:0] DST_ADDR         = 32'h0000_0010,
    parameter int          DATA_W           = 4,
    parameter int          POLL_CYCLES      = 50000,
    parameter int          DEBOUNCE_SAMPLES = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              enable,
    output logic [31:0]       avm_address,
    output logic              avm_read,
    output logic              avm_write,
    output logic [3:0]        avm_byteenable,
    output logic [31:0]       avm_writedata,
    input  logic [31:0]       avm_readdata,
    input  logic              avm_readdatavalid,
    input  logic              avm_waitrequest,
    output logic [DATA_W-1:0] value,
    output logic              changed,
    output logic              busy
);

    localparam int            TW     = $clog2(POLL_CYCLES);
    localparam logic [TW-1:0] RELOAD = TW'(POLL_CYCLES - 1);

    state_t            state;
    logic [TW-1:0]     timer;
    logic              poll_pending;
    logic              timer_expired;
    logic              poll_start;
    logic [DATA_W-1:0] sample;
    logic              sample_valid;
    logic              commit;
    logic              unused_readdata;

    // Only the low DATA_W bits of the read data are meaningful.
    assign unused_readdata = ^avm_readdata;

    assign avm_byteenable = BYTEENABLE_ALL;
    assign avm_writedata  = 32'(value);

    // ------------------------------------------------------------------
    // Poll timer. An expiry seen while IDLE starts the poll directly, so
    // the poll period is exactly POLL_CYCLES. Expiries while busy are
    // remembered in a single flag; several of them collapse into one poll.
    // ------------------------------------------------------------------
    assign timer_expired = enable && (timer == '0);
    assign poll_start    = enable && (poll_pending || timer_expired);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer        <= RELOAD;
            poll_pending <= 1'b0;
        end else begin
            if (!enable || (timer == '0)) begin
                timer <= RELOAD;
            end else begin
                timer <= timer - 1'b1;
            end

            // Leaving IDLE consumes the request, including an expiry that
            // lands in that same cycle.
            if ((state == IDLE) && poll_start) begin
                poll_pending <= 1'b0;
            end else if (timer_expired) begin
                poll_pending <= 1'b1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Debounce: fed one strobe per poll, during EVAL, with the latched
    // read data.
    // ------------------------------------------------------------------
    assign sample_valid = (state == EVAL);

    basic_system_pio_poller_debounce #(
        .DATA_W           (DATA_W),
        .DEBOUNCE_SAMPLES (DEBOUNCE_SAMPLES)
    ) u_debounce (
        .clk          (clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample       (sample),
        .value        (value),
        .commit       (commit)
    );

    // ------------------------------------------------------------------
    // Bus FSM with registered command, address and status outputs.
    // enable is only looked at in IDLE, so a started read/write sequence
    // always runs to completion.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            avm_read    <= 1'b0;
            avm_write   <= 1'b0;
            avm_address <= SRC_ADDR;
            sample      <= '0;
            changed     <= 1'b0;
            busy        <= 1'b0;
        end else begin
            changed <= 1'b0;
            case (state)
                IDLE: begin
                    if (poll_start) begin
                        state    <= RD_REQ;
                        avm_read <= 1'b1;
                        busy     <= 1'b1;
                    end
                end
                RD_REQ: begin
                    if (!avm_waitrequest) begin
                        state    <= RD_WAIT;
                        avm_read <= 1'b0;
                    end
                end
                RD_WAIT: begin
                    if (avm_readdatavalid) begin
                        sample <= avm_readdata[DATA_W-1:0];
                        state  <= EVAL;
                    end
                end
                EVAL: begin
                    if (commit) begin
                        state       <= WR_REQ;
                        avm_write   <= 1'b1;
                        avm_address <= DST_ADDR;
                    end else begin
                        state <= IDLE;
                        busy  <= 1'b0;
                    end
                end
                WR_REQ: begin
                    if (!avm_waitrequest) begin
                        state       <= IDLE;
                        avm_write   <= 1'b0;
                        avm_address <= SRC_ADDR;
                        changed     <= 1'b1;
                        busy        <= 1'b0;
                    end
                end
                default: begin
                    state       <= IDLE;
                    avm_read    <= 1'b0;
                    avm_write   <= 1'b0;
                    avm_address <= SRC_ADDR;
                    busy        <= 1'b0;
                end
            endcase
        end
    end

endmodule
